// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencing and hazard control.
// Holds one fetched instruction in a decode (D) slot, classifies it for the
// external immediate generator, checks its sources against a busy scoreboard
// and the execute (E) slot, and issues it into a registered E slot.

package decode_issue_pkg;
  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_e;
endpackage

module decode_issue_ctrl
  import decode_issue_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_instruction_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  output logic [31:0] imm_instruction_o,
  output logic [2:0]  imm_type_o,
  input  logic [31:0] imm_immediate_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_instruction_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_immediate_o,
  output logic [2:0]  ex_type_o,
  output logic        ex_illegal_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i
);

  // D slot
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;

  // E slot
  logic        e_valid;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic [31:0] e_imm;
  inst_type_e  e_type;
  logic        e_illegal;
  logic [4:0]  e_rd;
  logic        e_writes;

  // Scoreboard of destinations handed to execute but not yet written back
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Decode of the D slot; an empty slot presents an all-zero word
  logic [31:0] d_view;
  inst_type_e  d_type;
  logic        d_illegal;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        uses_rs1, uses_rs2, d_writes;
  logic        rs1_hazard, rs2_hazard, hazard;
  logic        e_free, issue, handoff;

  assign d_view = d_valid ? d_instr : '0;
  assign d_rd   = d_view[11:7];
  assign d_rs1  = d_view[19:15];
  assign d_rs2  = d_view[24:20];

  // Opcode classification; unknown opcodes fall back to R with illegal set
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    d_type    = INST_R;
    d_illegal = 1'b0;
    unique case (d_view[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: d_type = INST_I;
      7'b0100011: d_type = INST_S;
      7'b1100011: d_type = INST_B;
      7'b0110111, 7'b0010111: d_type = INST_U;
      7'b1101111: d_type = INST_J;
      7'b0110011: d_type = INST_R;
      default:    d_illegal = 1'b1;
    endcase
  end

  // Register usage derived from the class; illegal words touch nothing
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    d_writes = 1'b0;
    if (!d_illegal) begin
      uses_rs1 = (d_type == INST_I) || (d_type == INST_S) ||
                 (d_type == INST_B) || (d_type == INST_R);
      uses_rs2 = (d_type == INST_S) || (d_type == INST_B) || (d_type == INST_R);
      d_writes = ((d_type == INST_I) || (d_type == INST_U) ||
                  (d_type == INST_J) || (d_type == INST_R)) && (d_rd != 5'd0);
    end
  end

  // A source is blocked by a busy bit not being retired this cycle, or by a
  // pending write still sitting in the E slot
  always_comb begin
    rs1_hazard = 1'b0;
    rs2_hazard = 1'b0;
    if (uses_rs1 && (d_rs1 != 5'd0)) begin
      rs1_hazard = (busy_q[d_rs1] && !(wb_valid_i && (wb_rd_i == d_rs1))) ||
                   (e_valid && e_writes && (e_rd == d_rs1));
    end
    if (uses_rs2 && (d_rs2 != 5'd0)) begin
      rs2_hazard = (busy_q[d_rs2] && !(wb_valid_i && (wb_rd_i == d_rs2))) ||
                   (e_valid && e_writes && (e_rd == d_rs2));
    end
  end

  assign hazard     = rs1_hazard || rs2_hazard;
  assign e_free     = !e_valid || ex_ready_i;
  assign issue      = d_valid && !hazard && e_free && !flush_i;
  assign if_ready_o = !d_valid || issue;
  assign ex_valid_o = e_valid && !flush_i;
  assign handoff    = ex_valid_o && ex_ready_i && e_writes;

  assign imm_instruction_o = d_view;
  assign imm_type_o        = d_type;

  assign ex_instruction_o = e_instr;
  assign ex_pc_o          = e_pc;
  assign ex_immediate_o   = e_imm;
  assign ex_type_o        = e_type;
  assign ex_illegal_o     = e_illegal;

  // Next scoreboard: retire first, so a same-bit handoff set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
    if (handoff)    busy_d[e_rd]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  // D slot: refills whenever it is empty or its occupant issues
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      d_valid <= 1'b0;
      d_instr <= '0;
      d_pc    <= '0;
    end else if (flush_i) begin
      d_valid <= 1'b0;
    end else if (if_ready_o) begin
      d_valid <= if_valid_i;
      if (if_valid_i) begin
        d_instr <= if_instruction_i;
        d_pc    <= if_pc_i;
      end
    end
  end

  // E slot: loads on issue, empties on handoff without a replacement
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_valid   <= 1'b0;
      e_instr   <= '0;
      e_pc      <= '0;
      e_imm     <= '0;
      e_type    <= INST_R;
      e_illegal <= 1'b0;
      e_rd      <= '0;
      e_writes  <= 1'b0;
    end else if (flush_i) begin
      e_valid <= 1'b0;
    end else if (issue) begin
      e_valid   <= 1'b1;
      e_instr   <= d_instr;
      e_pc      <= d_pc;
      e_imm     <= imm_immediate_i;
      e_type    <= d_type;
      e_illegal <= d_illegal;
      e_rd      <= d_rd;
      e_writes  <= d_writes;
    end else if (ex_ready_i) begin
      e_valid <= 1'b0;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge clk_i) begin
    // NOTE: the scoreboard is a plain flop vector, not a RAM, so it takes a
    // reset; stale busy bits after reset would deadlock decode.
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule
